switch_key_frontend: RTL and testbench
======================================

Name: switch_key_frontend

Overview:
- Upstream stage of the 3-to-8 LED decoder; drives that decoder's `switch[2:0]` and `enable[2:0]` inputs directly.
- Takes three raw, bouncy slide switches and one raw push key, synchronises and debounces each one, and arms/disarms the decoder from the key.
- While armed: drives enable = 3'b100 (the decoder's only active code). While idle: drives 3'b000.
- Optionally disarms itself after a period with no switch activity.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles an input must differ from its stable value before the stable value updates (legal range 1..255).
- IDLE_TIMEOUT, 1000: cycles in ARMED with no debounced switch change before returning to IDLE; 0 disables the timeout.
- START_ARMED, 0: 1 selects ARMED as the state taken on reset.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- raw_switch  in  3  asynchronous slide-switch inputs
- raw_key  in  1  asynchronous push key, 1 = pressed
- switch  out  3  debounced switch value, to decoder switch
- enable  out  3  3'b100 when ARMED, 3'b000 when IDLE, to decoder enable
- chg  out  1  one-cycle pulse when switch changes while ARMED

Behaviour:
- Reset (rst=0, async):
  - sync flops, stable values and counters = 0; switch = 3'b000; chg = 0; timeout counter = 0.
  - state = IDLE with enable = 3'b000, or ARMED with enable = 3'b100 if START_ARMED = 1.
  - Reset asserted mid-debounce discards partial counts. Release is synchronous to clk in the bench.
- Per-input channel (4 instances: 3 switch bits + key):
  - Two-flop synchroniser s1 -> s2.
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0, with a one-cycle `upd` pulse.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches stable.
- Latency: a raw level first sampled at edge 0 appears on `switch` after edge DEBOUNCE_CYCLES+1. With DEBOUNCE_CYCLES = 4, that is visible after the 6th rising edge.
- Counter width: 8 bits; never wraps because it is bounded by DEBOUNCE_CYCLES-1.
- `switch` is the registered stable values of the three switch channels and updates in ARMED and IDLE alike.
- FSM (IDLE, ARMED):
  - A key press event is a 0->1 transition of the debounced key.
  - IDLE + key press -> ARMED.
  - ARMED + key press -> IDLE.
  - ARMED + timeout counter == IDLE_TIMEOUT-1 (IDLE_TIMEOUT > 0) -> IDLE.
  - Key release has no effect.
- `enable` is registered and decoded from the state: it changes on the same edge as the state.
- `chg` <= (any switch channel upd) && (state == ARMED), evaluated against the pre-edge state.
- Timeout counter:
  - Cleared in IDLE.
  - Cleared on any switch upd.
  - Cleared on entry to ARMED.
  - Otherwise increments in ARMED. Saturation is not needed because reaching the terminal count forces IDLE.
- Simultaneous events:
  - Key press and timeout in the same cycle -> IDLE.
  - Switch upd and timeout terminal count in the same cycle -> the upd wins: stay ARMED, counter cleared, chg = 1.
  - Key press arming in the same cycle as a switch upd -> ARMED, chg = 0.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ARMED);
  - constants EN_ACTIVE = 3'b100 and EN_OFF = 3'b000, shared with the decoder stage;
  - DB_CNT_W = 8.
- One sub-module, debounce_bit: synchroniser, counter, stable flop and upd pulse; parameterised by DEBOUNCE_CYCLES; instantiated four times.

Test Plan (DEBOUNCE_CYCLES = 4, IDLE_TIMEOUT = 16, START_ARMED = 0 unless noted):
- Reset then idle: hold rst=0 for 3 cycles, release -> switch = 000, enable = 000, chg = 0. With START_ARMED = 1 -> enable = 100.
- Debounced switch latency: raw_switch 000 -> 101 held steady -> switch becomes 101 exactly after the 6th rising edge; chg = 0 because the block is IDLE.
- Glitch rejection: raw_switch[0] pulses high for 3 cycles, then low -> switch stays 000 and chg never pulses.
- Arm and change: raw_key pressed for 8 cycles -> enable = 100; raw_switch 000 -> 011 -> switch = 011 with chg high for exactly one cycle on that edge.
- Timeout: arm, then hold switches steady -> enable returns to 000 after 16 cycles in ARMED. A switch change at cycle 15 (terminal count) keeps ARMED, restarts the 16-cycle count and pulses chg.
- Async reset mid-operation: while ARMED with a switch debounce half-counted, pull rst low between edges -> enable = 000, switch = 000 and chg = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/switch_key_frontend_pkg.sv
// ----------------------------------------------------------------------------
// switch_key_frontend_pkg
// Shared definitions for the switch/key front end and the 3-to-8 LED decoder
// stage that it feeds.
//   state_t     : arming state of the front end (IDLE, ARMED)
//   EN_ACTIVE   : decoder enable code that turns the decoder on
//   EN_OFF      : decoder enable code that keeps the decoder dark
//   DB_CNT_W    : width of every debounce counter
//   enable_code : maps an arming state to the decoder enable code
// ----------------------------------------------------------------------------
package switch_key_frontend_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [2:0] EN_ACTIVE = 3'b100;
    localparam logic [2:0] EN_OFF    = 3'b000;

    localparam int DB_CNT_W = 8;

    function automatic logic [2:0] enable_code(input state_t s);
        return (s == ST_ARMED) ? EN_ACTIVE : EN_OFF;
    endfunction

endpackage

// File: rtl/switch_key_frontend_if.sv
// ----------------------------------------------------------------------------
// switch_key_frontend_if
// Bundles the raw board inputs and the decoder-facing outputs of the front end.
//   raw_switch : raw, asynchronous slide switches
//   raw_key    : raw, asynchronous push key (1 = pressed)
//   switch     : debounced switch value, goes to the decoder switch input
//   enable     : decoder enable code (3'b100 armed, 3'b000 idle)
//   chg        : one-cycle pulse when the debounced switches change while armed
// Modports:
//   master : the board/stimulus side, drives the raw inputs
//   slave  : the front end, drives the decoder-facing outputs
// ----------------------------------------------------------------------------
interface switch_key_frontend_if;

    logic [2:0] raw_switch;
    logic       raw_key;
    logic [2:0] switch;
    logic [2:0] enable;
    logic       chg;

    modport master (
        output raw_switch,
        output raw_key,
        input  switch,
        input  enable,
        input  chg
    );

    modport slave (
        input  raw_switch,
        input  raw_key,
        output switch,
        output enable,
        output chg
    );

endinterface

// File: rtl/switch_key_frontend_debounce_bit.sv
// ----------------------------------------------------------------------------
// debounce_bit
// One input channel: two-flop synchroniser followed by a run-length debouncer.
// The stable value only follows the synchronised input after it has differed
// for DEBOUNCE_CYCLES consecutive cycles.
//   clk      : system clock
//   rst      : asynchronous reset, active low
//   i_raw    : raw asynchronous input
//   o_stable : debounced (stable) value
//   o_upd    : high in the cycle whose rising edge updates o_stable
// ----------------------------------------------------------------------------
module debounce_bit
    import switch_key_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_upd
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                r_s1;
    logic                r_s2;
    logic                r_stable;
    logic [DB_CNT_W-1:0] r_cnt;
    logic                w_diff;
    logic                w_done;

    assign w_diff = (r_s2 != r_stable);
    // Combinational so that downstream registers see the update on the same
    // edge that loads the new stable value.
    assign w_done = w_diff && (r_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Any cycle that agrees with the stable value restarts the run, so the
    // counter never exceeds CNT_LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (!w_diff) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_stable = r_stable;
    assign o_upd    = w_done;

endmodule

// File: rtl/switch_key_frontend.sv
// ----------------------------------------------------------------------------
// switch_key_frontend
// Debounces three slide switches and one push key, arms/disarms the 3-to-8 LED
// decoder from key presses, and disarms itself after IDLE_TIMEOUT cycles with
// no switch activity (0 disables the timeout).
//   clk : system clock
//   rst : asynchronous reset, active low
//   bus : switch_key_frontend_if.slave (raw inputs in, switch/enable/chg out)
// ----------------------------------------------------------------------------
module switch_key_frontend
    import switch_key_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IDLE_TIMEOUT    = 1000,
    parameter bit START_ARMED     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    switch_key_frontend_if.slave       bus
);

    localparam int          TO_W        = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);
    localparam state_t      RESET_STATE = START_ARMED ? ST_ARMED : ST_IDLE;

    logic [3:0]      w_raw;
    logic [3:0]      w_stable;
    logic [3:0]      w_upd;
    logic            w_key_press;
    logic            w_sw_upd;
    logic            w_timeout;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_enable;
    logic [2:0]      w_enable_nxt;
    logic            r_chg;
    logic            w_chg_nxt;
    logic [TO_W-1:0] r_to_cnt;

    // Channels 0..2 are the slide switches, channel 3 is the key.
    assign w_raw = {bus.raw_key, bus.raw_switch};

    for (genvar g = 0; g < 4; g++) begin : g_chan
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (w_raw[g]),
            .o_stable (w_stable[g]),
            .o_upd    (w_upd[g])
        );
    end

    // A press is the debounced key about to go 0 -> 1; releases are ignored.
    assign w_key_press = w_upd[3] && !w_stable[3];
    assign w_sw_upd    = |w_upd[2:0];
    assign w_timeout   = (IDLE_TIMEOUT > 0) && (r_to_cnt == TO_LAST);

    // State register, with enable and chg registered alongside so they change
    // on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RESET_STATE;
            r_enable <= enable_code(RESET_STATE);
            r_chg    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_enable <= w_enable_nxt;
            r_chg    <= w_chg_nxt;
        end
    end

    // Next-state logic. A key press always toggles; a switch update in the
    // terminal timeout cycle keeps the block armed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_key_press) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_key_press) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout && !w_sw_upd) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; chg looks at the pre-edge state so the arming edge
    // itself never reports a change.
    always_comb begin
        w_enable_nxt = enable_code(w_state_nxt);
        w_chg_nxt    = w_sw_upd && (r_state == ST_ARMED);
    end

    // Inactivity counter: runs only while staying armed, restarted by entry
    // into ARMED and by every debounced switch change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if ((r_state != ST_ARMED) || (w_state_nxt != ST_ARMED) || w_sw_upd) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign bus.switch = w_stable[2:0];
    assign bus.enable = r_enable;
    assign bus.chg    = r_chg;

endmodule

// File: tb/tb_switch_key_frontend.sv
// ----------------------------------------------------------------------------
// tb_switch_key_frontend
// Self-checking bench for switch_key_frontend (DEBOUNCE_CYCLES=4,
// IDLE_TIMEOUT=16). A second instance with START_ARMED=1 checks the armed
// reset state.
// ----------------------------------------------------------------------------
module tb_switch_key_frontend;

    localparam int DB = 4;
    localparam int TO = 16;

    typedef struct {
        logic [2:0] sw;
        logic       key;
        logic [2:0] expSw;
        logic [2:0] expEn;
        logic       expChg;
    } vec_t;

    logic clk;
    logic rst;

    switch_key_frontend_if bus();
    switch_key_frontend_if bus2();

    switch_key_frontend #(
        .DEBOUNCE_CYCLES (DB),
        .IDLE_TIMEOUT    (TO),
        .START_ARMED     (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    switch_key_frontend #(
        .DEBOUNCE_CYCLES (DB),
        .IDLE_TIMEOUT    (TO),
        .START_ARMED     (1'b1)
    ) dutArmed (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0] curSw;
    logic       curKey;

    // Reference model state: raw sample history per channel (index 0 is the
    // newest sample), debounced values, arming flag and last-activity edge.
    logic [DB:0] mHist [4];
    logic [3:0]  mStable;
    logic        mArmed;
    logic        mChg;
    int          mEdge;
    int          mLastAct;

    vec_t vecs[$];

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int ch = 0; ch < 4; ch++) mHist[ch] = '0;
        mStable  = 4'b0000;
        mArmed   = 1'b0;
        mChg     = 1'b0;
        mLastAct = mEdge;
    endtask

    // One rising edge of the reference model. A channel flips when the last
    // DB synchronised samples (raw samples two edges old) all disagree with
    // its debounced value.
    task automatic modelStep();
        logic [3:0] sampled;
        logic [3:0] upd;
        logic       keyPress;
        logic       anyUpd;
        logic       timeoutHit;
        mEdge++;
        sampled = {curKey, curSw};
        for (int ch = 0; ch < 4; ch++) begin
            upd[ch] = 1'b1;
            for (int k = 1; k <= DB; k++) begin
                if (mHist[ch][k] == mStable[ch]) upd[ch] = 1'b0;
            end
            mHist[ch] = {mHist[ch][DB-1:0], sampled[ch]};
        end
        keyPress   = upd[3] && !mStable[3];
        anyUpd     = |upd[2:0];
        mChg       = anyUpd && mArmed;
        timeoutHit = mArmed && (TO > 0) && ((mEdge - mLastAct) == TO);
        if (!mArmed) begin
            if (keyPress) begin
                mArmed   = 1'b1;
                mLastAct = mEdge;
            end
        end else if (keyPress) begin
            mArmed = 1'b0;
        end else if (anyUpd) begin
            mLastAct = mEdge;
        end else if (timeoutHit) begin
            mArmed = 1'b0;
        end
        mStable = mStable ^ upd;
    endtask

    // Drive inputs away from the edge, clock once, then compare against the
    // reference model one time unit after the edge.
    task automatic applyStimulus(input logic [2:0] sw, input logic key);
        curSw          = sw;
        curKey         = key;
        bus.raw_switch = sw;
        bus.raw_key    = key;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("model switch", {5'd0, bus.switch}, {5'd0, mStable[2:0]});
        checkOutput("model enable", {5'd0, bus.enable}, mArmed ? 8'h04 : 8'h00);
        checkOutput("model chg", {7'd0, bus.chg}, {7'd0, mChg});
    endtask

    task automatic addVec(input int n, input logic [2:0] sw, input logic key,
                          input logic [2:0] expSw, input logic [2:0] expEn, input logic expChg);
        vec_t v;
        v.sw = sw; v.key = key; v.expSw = expSw; v.expEn = expEn; v.expChg = expChg;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        bus2.raw_switch = 3'b000;
        bus2.raw_key    = 1'b0;
        curSw           = 3'b000;
        curKey          = 1'b0;
        bus.raw_switch  = 3'b000;
        bus.raw_key     = 1'b0;
        mEdge           = 0;
        modelReset();

        // Reset held for three cycles, released between edges.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset switch", {5'd0, bus.switch}, 8'h00);
        checkOutput("reset enable", {5'd0, bus.enable}, 8'h00);
        checkOutput("reset chg", {7'd0, bus.chg}, 8'h00);
        checkOutput("reset enable armed", {5'd0, bus2.enable}, 8'h04);

        // Latency, glitch rejection, arming by key, switch change while armed.
        addVec(5, 3'b101, 1'b0, 3'b000, 3'b000, 1'b0);
        addVec(2, 3'b101, 1'b0, 3'b101, 3'b000, 1'b0);
        addVec(3, 3'b111, 1'b0, 3'b101, 3'b000, 1'b0);
        addVec(6, 3'b101, 1'b0, 3'b101, 3'b000, 1'b0);
        addVec(5, 3'b101, 1'b1, 3'b101, 3'b000, 1'b0);
        addVec(3, 3'b101, 1'b1, 3'b101, 3'b100, 1'b0);
        addVec(5, 3'b011, 1'b0, 3'b101, 3'b100, 1'b0);
        addVec(1, 3'b011, 1'b0, 3'b011, 3'b100, 1'b1);
        addVec(1, 3'b011, 1'b0, 3'b011, 3'b100, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sw, vecs[i].key);
            checkOutput($sformatf("vec%0d switch", i), {5'd0, bus.switch}, {5'd0, vecs[i].expSw});
            checkOutput($sformatf("vec%0d enable", i), {5'd0, bus.enable}, {5'd0, vecs[i].expEn});
            checkOutput($sformatf("vec%0d chg", i), {7'd0, bus.chg}, {7'd0, vecs[i].expChg});
        end

        // Timeout: last activity was the switch change; IDLE after 16 quiet cycles.
        for (int k = 2; k <= TO; k++) begin
            applyStimulus(3'b011, 1'b0);
            checkOutput($sformatf("timeout k%0d enable", k), {5'd0, bus.enable},
                        (k < TO) ? 8'h04 : 8'h00);
        end

        // Re-arm, then land a switch change exactly on the terminal count.
        for (int t = 1; t <= 38; t++) begin
            applyStimulus((t >= 17) ? 3'b110 : 3'b011, (t <= 8));
            if (t == 5)  checkOutput("rearm before", {5'd0, bus.enable}, 8'h00);
            if (t == 6)  checkOutput("rearm enable", {5'd0, bus.enable}, 8'h04);
            if (t == 21) checkOutput("terminal-1 switch", {5'd0, bus.switch}, 8'h03);
            if (t == 22) begin
                checkOutput("terminal enable", {5'd0, bus.enable}, 8'h04);
                checkOutput("terminal switch", {5'd0, bus.switch}, 8'h06);
                checkOutput("terminal chg", {7'd0, bus.chg}, 8'h01);
            end
            if (t == 23) checkOutput("terminal+1 chg", {7'd0, bus.chg}, 8'h00);
            if (t == 37) checkOutput("restart enable", {5'd0, bus.enable}, 8'h04);
            if (t == 38) checkOutput("restart timeout", {5'd0, bus.enable}, 8'h00);
        end

        // Arm again, start a switch debounce, then reset between edges.
        for (int t = 1; t <= 11; t++) begin
            applyStimulus((t >= 9) ? 3'b101 : 3'b110, (t <= 8));
        end
        checkOutput("pre-reset enable", {5'd0, bus.enable}, 8'h04);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async enable", {5'd0, bus.enable}, 8'h00);
        checkOutput("async switch", {5'd0, bus.switch}, 8'h00);
        checkOutput("async chg", {7'd0, bus.chg}, 8'h00);
        checkOutput("async enable armed", {5'd0, bus2.enable}, 8'h04);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        // Partial count must be gone: full latency again from release.
        for (int t = 1; t <= 6; t++) begin
            applyStimulus(3'b101, 1'b0);
            checkOutput($sformatf("post-reset t%0d switch", t), {5'd0, bus.switch},
                        (t < 6) ? 8'h00 : 8'h05);
        end

        // Randomised traffic: occasional new switch words, single-bit flips
        // (often shorter than the debounce window) and key toggles.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] sw;
            logic       key;
            int         r;
            sw  = curSw;
            key = curKey;
            r   = int'($urandom_range(0, 19));
            if (r == 0) sw = 3'($urandom_range(0, 7));
            else if (r == 1) sw = sw ^ (3'b001 << $urandom_range(0, 2));
            else if (r == 2) key = !key;
            applyStimulus(sw, key);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
